// File: rtl/mux2_arbiter_64bit.sv
// Two-source round-robin burst arbiter feeding one registered 64-bit output stage.
// A grant lasts until the source's last beat or MAX_BURST beats, whichever comes first.
module mux2_arbiter_64bit #(
  parameter int MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] in0_data,
  input  logic        in0_valid,
  input  logic        in0_last,
  output logic        in0_ready,
  input  logic [63:0] in1_data,
  input  logic        in1_valid,
  input  logic        in1_last,
  output logic        in1_ready,
  output logic [63:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        sel
);

  localparam int CW = $clog2(MAX_BURST + 1);
  // Counter value seen while the MAX_BURST-th beat of a grant is transferring.
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1
  } state_t;

  state_t        state;
  logic          rr;
  logic [CW-1:0] beat_cnt;

  logic          out_free;
  logic          xfer0;
  logic          xfer1;
  logic          xfer;
  logic [63:0]   xfer_data;
  logic          xfer_last;
  logic          burst_end;

  // The output register can take a beat when empty or draining this edge.
  assign out_free  = !out_valid || out_ready;
  assign in0_ready = (state == LOCK0) && out_free;
  assign in1_ready = (state == LOCK1) && out_free;

  assign xfer0     = in0_valid && in0_ready;
  assign xfer1     = in1_valid && in1_ready;
  assign xfer      = xfer0 || xfer1;
  assign xfer_data = xfer1 ? in1_data : in0_data;
  assign xfer_last = xfer1 ? in1_last : in0_last;
  assign burst_end = xfer_last || (beat_cnt == LAST_IDX);

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the 64-bit data register is reset too, since out_data must read 0
      // straight out of reset rather than whatever it held before.
      state     <= IDLE;
      rr        <= 1'b1;
      beat_cnt  <= '0;
      sel       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (xfer) begin
        out_data  <= xfer_data;
        out_last  <= xfer_last;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          beat_cnt <= '0;
          // On a tie, rr == 1 means in1 went last, so in0 wins.
          if (in0_valid && (!in1_valid || rr)) begin
            state <= LOCK0;
            sel   <= 1'b0;
          end else if (in1_valid) begin
            state <= LOCK1;
            sel   <= 1'b1;
          end
        end
        LOCK0, LOCK1: begin
          if (xfer) begin
            if (burst_end) begin
              state    <= IDLE;
              rr       <= (state == LOCK1);
              sel      <= 1'b0;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          sel   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_arbiter_64bit.sv
// Bench for mux2_arbiter_64bit: directed timing/reset steps plus randomized bursts
// checked against a burst-level round-robin model of the expected output order.
module tb_mux2_arbiter_64bit;

  localparam int MB = 4;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  bit          clk_en = 1'b0;
  logic        rst;
  logic [63:0] in0_data, in1_data, out_data;
  logic        in0_valid, in0_last, in0_ready;
  logic        in1_valid, in1_last, in1_ready;
  logic        out_valid, out_last, out_ready, sel;

  mux2_arbiter_64bit #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .sel(sel)
  );

  always #5 if (clk_en) clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  beat_t       q0[$];
  beat_t       q1[$];
  logic [64:0] exp_q[$];
  bit          m_rr;
  bit          ordy;
  bit          rand_ordy;
  bit          log_en;
  int          edge_n;
  int          del_log[$];
  logic        s_in0_ready, s_in1_ready, s_ov, s_ol, s_sel;
  logic [63:0] s_od;
  logic [63:0] held;
  int          exp_edges[6] = '{3, 4, 6, 7, 9, 10};

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_burst(input bit src, input int len, input bit rnd, input logic [63:0] base);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = rnd ? {$urandom, $urandom} : base + 64'(i);
      b.last = (i == len - 1);
      if (src) q1.push_back(b);
      else     q0.push_back(b);
    end
  endtask

  // Expected delivery order: both sources stay valid while they have beats, so
  // each grant alternates when both are pending and lasts up to last or MB beats.
  task automatic plan();
    beat_t c0[$];
    beat_t c1[$];
    c0 = q0;
    c1 = q1;
    while (c0.size() > 0 || c1.size() > 0) begin
      bit src;
      int n;
      if (c0.size() > 0 && c1.size() > 0) src = !m_rr;
      else                                src = (c1.size() > 0);
      n = 0;
      forever begin
        beat_t b;
        if (src) b = c1.pop_front();
        else     b = c0.pop_front();
        exp_q.push_back({b.last, b.data});
        n++;
        if (b.last || n == MB || (src ? c1.size() == 0 : c0.size() == 0)) break;
      end
      m_rr = src;
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    bit h0, h1, ho;
    if (rand_ordy) ordy = ($urandom_range(0, 3) != 0);
    out_ready = ordy;
    in0_valid = (q0.size() > 0);
    in1_valid = (q1.size() > 0);
    if (q0.size() > 0) begin in0_data = q0[0].data; in0_last = q0[0].last; end
    else begin in0_data = {$urandom, $urandom}; in0_last = 1'($urandom); end
    if (q1.size() > 0) begin in1_data = q1[0].data; in1_last = q1[0].last; end
    else begin in1_data = {$urandom, $urandom}; in1_last = 1'($urandom); end
    #1;
    s_in0_ready = in0_ready; s_in1_ready = in1_ready;
    s_ov = out_valid; s_od = out_data; s_ol = out_last; s_sel = sel;
    h0 = in0_valid && in0_ready;
    h1 = in1_valid && in1_ready;
    ho = out_valid && out_ready;
    @(posedge clk);
    edge_n++;
    if (h0) void'(q0.pop_front());
    if (h1) void'(q1.pop_front());
    check("one_ready", 65'(s_in0_ready && s_in1_ready), 65'd0);
    if (ho) begin
      if (log_en) del_log.push_back(edge_n);
      check("sb_beat_expected", 65'(exp_q.size() != 0), 65'd1);
      if (exp_q.size() != 0) check("sb_beat", {s_ol, s_od}, exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic run_until_empty(input int budget, input string tag);
    int cyc = 0;
    while ((q0.size() + q1.size() + exp_q.size()) != 0 && cyc < budget) begin
      step();
      cyc++;
    end
    check({"drain_", tag}, 65'(q0.size() + q1.size() + exp_q.size()), 65'd0);
  endtask

  initial begin
    rst = 1'b0; out_ready = 1'b0; ordy = 1'b1; rand_ordy = 1'b0; log_en = 1'b0; m_rr = 1'b1;
    in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
    in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;

    // Reset with no clock running.
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", 65'(out_valid), 65'd0);
    check("rst_out_data", 65'(out_data), 65'd0);
    check("rst_out_last", 65'(out_last), 65'd0);
    check("rst_sel", 65'(sel), 65'd0);
    check("rst_in0_ready", 65'(in0_ready), 65'd0);
    check("rst_in1_ready", 65'(in1_ready), 65'd0);

    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    edge_n = 0;

    // Tie right after reset: in0, in1, in0 with one IDLE cycle between bursts.
    add_burst(0, 2, 0, 64'hA0);
    add_burst(1, 2, 0, 64'hB0);
    add_burst(0, 2, 0, 64'hA2);
    plan();
    log_en = 1'b1;
    run_until_empty(100, "tie");
    log_en = 1'b0;
    check("tie_deliveries", 65'(del_log.size()), 65'd6);
    for (int i = 0; i < 6; i++)
      if (i < del_log.size()) check($sformatf("tie_edge%0d", i), 65'(del_log[i]), 65'(exp_edges[i]));

    // Single in0 burst, cycle by cycle.
    add_burst(0, 3, 0, 64'h1);
    plan();
    ordy = 1'b1;
    step();
    check("sb_idle_ready", 65'(s_in0_ready), 65'd0);
    check("sb_arb_valid", 65'(out_valid), 65'd0);
    check("sb_arb_sel", 65'(sel), 65'd0);
    step();
    check("sb_b1_ready0", 65'(s_in0_ready), 65'd1);
    check("sb_b1_ready1", 65'(s_in1_ready), 65'd0);
    check("sb_b1", {out_valid, out_last, out_data}, {1'b1, 1'b0, 64'h1});
    step();
    check("sb_b2_ready1", 65'(s_in1_ready), 65'd0);
    check("sb_b2", {out_valid, out_last, out_data}, {1'b1, 1'b0, 64'h2});
    step();
    check("sb_b3_ready1", 65'(s_in1_ready), 65'd0);
    check("sb_b3", {out_valid, out_last, out_data}, {1'b1, 1'b1, 64'h3});
    check("sb_b3_sel", 65'(sel), 65'd0);
    step();
    check("sb_gap_ready", 65'({s_in0_ready, s_in1_ready}), 65'd0);
    check("sb_gap_valid", 65'(out_valid), 65'd0);
    check("sb_done", 65'(exp_q.size()), 65'd0);

    // Forced release: in1 wins the tie, gives up after MB beats, resumes later.
    add_burst(1, 6, 0, 64'hC0);
    add_burst(0, 3, 0, 64'hD0);
    plan();
    run_until_empty(200, "forced");

    // Backpressure during an in1 burst.
    add_burst(1, 3, 0, 64'hE0);
    plan();
    ordy = 1'b1;
    step();
    step();
    held = out_data;
    check("bp_first", 65'(held), 65'hE0);
    ordy = 1'b0;
    repeat (3) begin
      step();
      check("bp_ready", 65'(s_in1_ready), 65'd0);
      check("bp_hold", {s_ov, s_od}, {1'b1, held});
      check("bp_sel", 65'(s_sel), 65'd1);
    end
    ordy = 1'b1;
    run_until_empty(100, "bp");

    // Randomized bursts, lengths past MB, random downstream stalls.
    rand_ordy = 1'b1;
    for (int r = 0; r < 20; r++) begin
      for (int s = 0; s < 2; s++) begin
        int nb = $urandom_range(0, 3);
        for (int k = 0; k < nb; k++) add_burst(1'(s), $urandom_range(1, 7), 1, 64'h0);
      end
      plan();
      run_until_empty(600, "rand");
    end
    rand_ordy = 1'b0;
    ordy = 1'b1;

    // Async reset mid-burst in LOCK0 with a held beat; rr must return to 1.
    add_burst(0, 1, 0, 64'hF0);
    plan();
    run_until_empty(50, "pre_rst");
    add_burst(0, 5, 0, 64'hF8);
    ordy = 1'b0;
    step();
    step();
    check("mid_loaded", {out_valid, out_data}, {1'b1, 64'hF8});
    out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("mid_out_valid", 65'(out_valid), 65'd0);
    check("mid_out_data", 65'(out_data), 65'd0);
    check("mid_out_last", 65'(out_last), 65'd0);
    check("mid_sel", 65'(sel), 65'd0);
    check("mid_in0_ready", 65'(in0_ready), 65'd0);
    q0.delete();
    q1.delete();
    exp_q.delete();
    in0_valid = 1'b0;
    m_rr = 1'b1;
    ordy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    add_burst(1, 2, 0, 64'h90);
    add_burst(0, 2, 0, 64'h80);
    plan();
    run_until_empty(100, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
